// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path (and a future receive path).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_tx_state_t;

  localparam int unsigned UART_MIN_DATA_BITS = 5;

  // Out-of-range character widths saturate to the supported window.
  function automatic logic [3:0] uart_clamp_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'(UART_MIN_DATA_BITS)) begin
      return 4'(UART_MIN_DATA_BITS);
    end else if (req > max_bits) begin
      return max_bits;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       push_ready,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ready = !full;
  assign level      = LW'(wr_ptr_q - rd_ptr_q);
  assign pop_data   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter: TX FIFO feeding a frame engine with per-frame
// latched width, parity, stop-bit count and baud divider.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                       tx_clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic [3:0]                 cfg_data_bits,
  input  logic                       cfg_parity_en,
  input  logic                       cfg_parity_odd,
  input  logic                       cfg_two_stop,
  input  logic [DIV_W-1:0]           cfg_baud_div,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       frame_done
);

  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  uart_tx_state_t    state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [3:0]        nbits_q, nbits_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              two_stop_q, two_stop_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              fifo_pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              bit_end;
  logic              load;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (tx_clk),
    .rst        (rst),
    .push       (wr_valid),
    .push_data  (wr_data),
    .push_ready (wr_ready),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .empty      (fifo_empty),
    .level      (level)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    nbits_d    = nbits_q;
    shift_d    = shift_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    bit_end    = (cnt_q == '0);

    if (state_q != IDLE) begin
      cnt_d = bit_end ? div_q : cnt_q - DIV_ONE;
    end

    case (state_q)
      IDLE: begin
        load = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (bit_q == nbits_q - 4'd1) begin
            state_d = par_en_q ? PARITY : STOP1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (bit_end) begin
          if (two_stop_q) begin
            state_d = STOP2;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
            load    = !fifo_empty;
          end
        end
      end
      STOP2: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
          load    = !fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop from IDLE or from the last stop cycle goes straight to START,
    // so back-to-back frames have no idle gap.
    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = START;
      shift_d    = fifo_data;
      nbits_d    = uart_clamp_bits(cfg_data_bits, 4'(DATA_W));
      par_en_d   = cfg_parity_en;
      par_odd_d  = cfg_parity_odd;
      two_stop_d = cfg_two_stop;
      div_d      = cfg_baud_div;
      cnt_d      = cfg_baud_div;
      par_d      = 1'b0;
      bit_d      = '0;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d ^ par_odd_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      nbits_q    <= 4'(UART_MIN_DATA_BITS);
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule
